dlx_mem_stage: RTL
==================

Name: dlx_mem_stage

Overview:
- Pipeline stage directly downstream of the ALU in the DLX core. Consumes the ALU result as a data-memory address (loads/stores) or as a pass-through result (all other ops).
- Runs the data-memory request/acknowledge handshake, including byte/halfword alignment, sign/zero extension and bus timeout.
- Drives the write-back stage and stalls the execute stage while an access is outstanding.

Parameters:
TIMEOUT, 16, number of cycles in ACCESS without dm_ack before the access is aborted with bus_err (range 2..255)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
ex_valid  in  1  execute stage presents an op
ex_ready  out  1  stage can accept; combinational, = (state==IDLE)
ex_alu_out  in  32  ALU result: address for memory ops, result otherwise
ex_store_data  in  32  register value to store (right-justified)
ex_mem_read  in  1  load op
ex_mem_write  in  1  store op
ex_size  in  2  00 byte, 01 half, 10/11 word
ex_unsigned  in  1  zero-extend loads (LBU/LHU)
ex_rd  in  5  destination register
ex_reg_write  in  1  op writes a register
dm_req  out  1  memory request, held until ack
dm_we  out  1  1 = write
dm_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dm_wdata  out  32  lane-replicated store data
dm_be  out  4  byte enables; dm_be[3] = bits 31:24
dm_ack  in  1  memory completes access this cycle
dm_rdata  in  32  read data, valid when dm_ack
wb_valid  out  1  one-cycle pulse per retired op
wb_rd  out  5  destination register
wb_reg_write  out  1  register write enable (qualified)
wb_data  out  32  result to write back
misalign_exc  out  1  pulse with wb_valid: misaligned access
bus_err  out  1  pulse with wb_valid: access timed out

Behaviour:
- Reset: state IDLE; dm_req, dm_we, dm_be, dm_addr, dm_wdata, wb_valid, wb_rd, wb_reg_write, wb_data, misalign_exc, bus_err all 0; timeout counter 0; ex_ready=1 from the first post-reset cycle.
- Accept: when ex_valid & ex_ready, all ex_* inputs are registered. ex_valid with ex_ready=0 is ignored; upstream must hold the op.
- Big-endian byte order: offset 0 selects bits 31:24.
- Non-memory op (read=0, write=0): wb_valid at T+1, wb_data=ex_alu_out, wb_reg_write=ex_reg_write. Throughput is one op per cycle.
- Both read and write asserted: the op is treated as a store.
- Alignment rules: half requires addr[0]=0; word requires addr[1:0]=00.
- Misaligned op:
  - No memory access is made.
  - At T+1: wb_valid=1, misalign_exc=1, wb_reg_write=0, wb_data=address.
- Aligned memory op: state IDLE -> ACCESS at T+1.
  - dm_req=1 while in ACCESS; dm_addr, dm_we, dm_be and dm_wdata stay stable until ack.
  - dm_be: byte = one-hot by offset (offset 0 -> 1000); half = 1100 (offset 0) or 0011 (offset 2); word = 1111.
  - dm_wdata: byte replicated x4; half replicated x2; word as-is.
- ACCESS -> IDLE on the cycle dm_ack=1 is sampled (cycle A). At A+1:
  - dm_req=0, wb_valid=1, ex_ready=1.
  - Load: wb_data = selected lane, sign-extended (or zero-extended if ex_unsigned); wb_reg_write = ex_reg_write.
  - Store: wb_reg_write=0, wb_data=address.
  - A new op may be accepted at A+1.
- Timeout:
  - The counter resets on entry to ACCESS and increments each ACCESS cycle without ack.
  - On the TIMEOUT-th such cycle: ACCESS -> IDLE; the next cycle has wb_valid=1, bus_err=1, wb_reg_write=0, dm_req=0.
  - If dm_ack arrives on the same cycle the count reaches TIMEOUT, ack wins (normal completion).
- dm_ack while not in ACCESS is ignored.
- rst during ACCESS: the next cycle is IDLE with dm_req=0 and no wb_valid. The access is abandoned, and the memory must tolerate a dropped request.
- wb_valid, misalign_exc and bus_err are single-cycle pulses. wb_rd, wb_data and wb_reg_write hold their last value otherwise; wb_reg_write is only meaningful with wb_valid.
- At most one wb_valid per accepted op. No wb_valid for ops not accepted.

Test Plan:
- Reset then ADD pass-through: ex_alu_out=0x0000_1234, rd=5, reg_write=1 at T -> wb_valid at T+1, wb_data=0x1234, wb_rd=5; three back-to-back ops retire on three consecutive cycles.
- LB signed at 0x103, memory acks 3 cycles after request with dm_rdata=0x1122_3380 -> dm_addr=0x100, dm_be=0001, ex_ready=0 during ACCESS; wb_data=0xFFFF_FF80 the cycle after ack; LBU on the same data -> 0x0000_0080.
- SH at 0x202, store_data=0x0000_ABCD -> dm_we=1, dm_be=0011, dm_wdata=0xABCD_ABCD; after ack wb_valid=1, wb_reg_write=0.
- LW at 0x301 -> no dm_req ever; next cycle misalign_exc=1, wb_valid=1, wb_reg_write=0, wb_data=0x301.
- LW at 0x400 with TIMEOUT=4, no ack -> dm_req high exactly 4 cycles, then bus_err=1 with wb_valid=1; repeat with ack on the 4th cycle -> normal completion, no bus_err.
- rst asserted on the second ACCESS cycle of a load -> dm_req=0 next cycle, no wb_valid, ex_ready=1; a late dm_ack afterwards has no effect.

Source files
------------

// File: rtl/dlx_mem_stage_if.sv
// Execute / data-memory / write-back signal bundle for the DLX memory stage.
// slave = the memory stage itself, master = its surroundings.
interface dlx_mem_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        misalign_exc;
  logic        bus_err;

  modport slave (
    input  ex_valid, ex_alu_out, ex_store_data, ex_mem_read, ex_mem_write,
           ex_size, ex_unsigned, ex_rd, ex_reg_write, dm_ack, dm_rdata,
    output ex_ready, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
           wb_valid, wb_rd, wb_reg_write, wb_data, misalign_exc, bus_err
  );

  modport master (
    output ex_valid, ex_alu_out, ex_store_data, ex_mem_read, ex_mem_write,
           ex_size, ex_unsigned, ex_rd, ex_reg_write, dm_ack, dm_rdata,
    input  ex_ready, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
           wb_valid, wb_rd, wb_reg_write, wb_data, misalign_exc, bus_err
  );
endinterface

// File: rtl/dlx_mem_stage.sv
// DLX memory stage: big-endian byte/half/word data-memory access with
// alignment check, load extension, bus timeout and write-back pulse.
module dlx_mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  dlx_mem_stage_if.slave  bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] op_addr;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic        op_store;
  logic        op_reg_write;
  logic [4:0]  op_rd;

  logic        accept;
  logic        is_mem;
  logic        misaligned;
  logic [3:0]  be_nx;
  logic [31:0] wdata_nx;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;

  assign bus.ex_ready = (state == IDLE);
  assign accept       = bus.ex_valid & bus.ex_ready;
  assign is_mem       = bus.ex_mem_read | bus.ex_mem_write;

  always_comb begin
    misaligned = is_mem & (((bus.ex_size == 2'b01) & bus.ex_alu_out[0]) |
                           (bus.ex_size[1] & (|bus.ex_alu_out[1:0])));
    case (bus.ex_size)
      2'b00: begin
        be_nx    = 4'b1000 >> bus.ex_alu_out[1:0];
        wdata_nx = {4{bus.ex_store_data[7:0]}};
      end
      2'b01: begin
        be_nx    = bus.ex_alu_out[1] ? 4'b0011 : 4'b1100;
        wdata_nx = {2{bus.ex_store_data[15:0]}};
      end
      default: begin
        be_nx    = 4'b1111;
        wdata_nx = bus.ex_store_data;
      end
    endcase
  end

  // Offset 0 is the most significant lane (big-endian).
  always_comb begin
    case (op_addr[1:0])
      2'd0:    ld_byte = bus.dm_rdata[31:24];
      2'd1:    ld_byte = bus.dm_rdata[23:16];
      2'd2:    ld_byte = bus.dm_rdata[15:8];
      default: ld_byte = bus.dm_rdata[7:0];
    endcase
    ld_half = op_addr[1] ? bus.dm_rdata[15:0] : bus.dm_rdata[31:16];
    case (op_size)
      2'b00:   load_val = {{24{~op_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   load_val = {{16{~op_unsigned & ld_half[15]}}, ld_half};
      default: load_val = bus.dm_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      op_addr          <= '0;
      op_size          <= '0;
      op_unsigned      <= 1'b0;
      op_store         <= 1'b0;
      op_reg_write     <= 1'b0;
      op_rd            <= '0;
      bus.dm_req       <= 1'b0;
      bus.dm_we        <= 1'b0;
      bus.dm_addr      <= '0;
      bus.dm_wdata     <= '0;
      bus.dm_be        <= '0;
      bus.wb_valid     <= 1'b0;
      bus.wb_rd        <= '0;
      bus.wb_reg_write <= 1'b0;
      bus.wb_data      <= '0;
      bus.misalign_exc <= 1'b0;
      bus.bus_err      <= 1'b0;
    end else begin
      bus.wb_valid     <= 1'b0;
      bus.misalign_exc <= 1'b0;
      bus.bus_err      <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_addr      <= bus.ex_alu_out;
          op_size      <= bus.ex_size;
          op_unsigned  <= bus.ex_unsigned;
          op_store     <= bus.ex_mem_write;
          op_reg_write <= bus.ex_reg_write;
          op_rd        <= bus.ex_rd;
          if (!is_mem) begin
            bus.wb_valid     <= 1'b1;
            bus.wb_rd        <= bus.ex_rd;
            bus.wb_reg_write <= bus.ex_reg_write;
            bus.wb_data      <= bus.ex_alu_out;
          end else if (misaligned) begin
            bus.wb_valid     <= 1'b1;
            bus.misalign_exc <= 1'b1;
            bus.wb_rd        <= bus.ex_rd;
            bus.wb_reg_write <= 1'b0;
            bus.wb_data      <= bus.ex_alu_out;
          end else begin
            state        <= ACCESS;
            cnt          <= '0;
            bus.dm_req   <= 1'b1;
            bus.dm_we    <= bus.ex_mem_write;
            bus.dm_addr  <= {bus.ex_alu_out[31:2], 2'b00};
            bus.dm_be    <= be_nx;
            bus.dm_wdata <= wdata_nx;
          end
        end
        ACCESS: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (bus.dm_ack) begin
            state            <= IDLE;
            bus.dm_req       <= 1'b0;
            bus.wb_valid     <= 1'b1;
            bus.wb_rd        <= op_rd;
            bus.wb_reg_write <= op_store ? 1'b0 : op_reg_write;
            bus.wb_data      <= op_store ? op_addr : load_val;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            state            <= IDLE;
            bus.dm_req       <= 1'b0;
            bus.wb_valid     <= 1'b1;
            bus.bus_err      <= 1'b1;
            bus.wb_rd        <= op_rd;
            bus.wb_reg_write <= 1'b0;
            bus.wb_data      <= op_addr;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
